// File: rtl/visor_sg_mag_pkg.sv
// Shared glyphs, anode constants and helpers for the signed-magnitude display.
// Segment order is {g,f,e,d,c,b,a}, all active-low.
package visor_sg_mag_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Decoder code for the minus sign, outside the 0..9 digit range
  localparam logic [3:0] DIG_MINUS = 4'd10;

  typedef struct packed {
    logic [3:0] dig;
    logic       blank;
  } glyph_sel_t;

  function automatic logic [3:0] units(
    input logic [3:0] v
  );
    return (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

  function automatic logic [3:0] an_sel(
    input logic [1:0] i
  );
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/dec_7seg.sv
// Digit / minus-sign to active-low 7-segment glyph decoder.
// Blank overrides the digit code.
module dec_7seg
  import visor_sg_mag_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      unique case (digit)
        4'd0:      seg = SEG_0;
        4'd1:      seg = SEG_1;
        4'd2:      seg = SEG_2;
        4'd3:      seg = SEG_3;
        4'd4:      seg = SEG_4;
        4'd5:      seg = SEG_5;
        4'd6:      seg = SEG_6;
        4'd7:      seg = SEG_7;
        4'd8:      seg = SEG_8;
        4'd9:      seg = SEG_9;
        DIG_MINUS: seg = SEG_MINUS;
        default:   seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/visor_sg_mag.sv
// Signed-magnitude display stage: capture register, digit scan with
// ghost-suppression gap, and registered anode/segment drive.
module visor_sg_mag
  import visor_sg_mag_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int GAP = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] mag,
  input  logic       sg,
  input  logic       en,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GAP_C   = PW'(GAP);

  logic [PW-1:0] pc;
  logic [PW-1:0] pc_n;
  logic [1:0]    idx;
  logic [1:0]    idx_n;
  logic [3:0]    vmag;
  logic [3:0]    vmag_n;
  logic          vsg;
  logic          vsg_n;
  logic          tick;
  glyph_sel_t    sel;
  logic [6:0]    seg_n;
  logic [3:0]    an_n;

  // Outputs are derived from next-state values so pins stay in step
  always_comb begin
    tick   = (pc == PC_LAST);
    pc_n   = tick ? '0 : pc + PW'(1);
    idx_n  = idx + {1'b0, tick};
    vmag_n = ld ? mag : vmag;
    vsg_n  = ld ? sg : vsg;
  end

  always_comb begin
    sel.dig   = '0;
    sel.blank = 1'b1;
    unique case (idx_n)
      2'd0: begin
        sel.dig   = units(vmag_n);
        sel.blank = 1'b0;
      end
      2'd1: begin
        sel.dig   = 4'd1;
        sel.blank = (vmag_n < 4'd10);
      end
      2'd2: begin
        sel.dig   = '0;
        sel.blank = 1'b1;
      end
      2'd3: begin
        // Negative zero shows no sign
        sel.dig   = DIG_MINUS;
        sel.blank = !(vsg_n && (vmag_n != 4'd0));
      end
      default: begin
        sel.dig   = '0;
        sel.blank = 1'b1;
      end
    endcase
  end

  dec_7seg u_dec (
    .digit (sel.dig),
    .blank (sel.blank),
    .seg   (seg_n)
  );

  always_comb begin
    an_n = AN_OFF;
    if (en && (pc_n >= GAP_C)) begin
      an_n = an_sel(idx_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      idx  <= '0;
      vmag <= '0;
      vsg  <= 1'b0;
      an   <= AN_OFF;
      seg  <= SEG_0;
    end else begin
      pc   <= pc_n;
      idx  <= idx_n;
      vmag <= vmag_n;
      vsg  <= vsg_n;
      an   <= an_n;
      seg  <= seg_n;
    end
  end

endmodule

// File: tb/tb_visor_sg_mag.sv
// Bench for visor_sg_mag: vector table, corner sequences and random
// stimulus against a time-based model of the signed decimal display.
module tb_visor_sg_mag;

  localparam int DIV = 8;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] mag = 4'd0;
  logic       sg = 1'b0;
  logic       en = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;

  always #5 clk = ~clk;

  visor_sg_mag #(
    .DIV (DIV),
    .GAP (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .mag   (mag),
    .sg    (sg),
    .en    (en),
    .an    (an),
    .seg   (seg)
  );

  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] glyph [0:9];

  int tests = 0;
  int fails = 0;

  // Model: edges since reset, captured value, last sampled enable
  int t = 0;
  int m_val = 0;
  bit m_neg = 1'b0;
  bit m_en = 1'b1;

  typedef struct {
    logic [3:0] mag;
    logic       sg;
    logic [6:0] d0;
    logic [6:0] d1;
    logic [6:0] d3;
  } vec_t;

  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got %b expected %b", name, t, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_glyph(input int d);
    int a;
    a = m_val;
    case (d)
      0: return glyph[a % 10];
      1: return (a / 10 != 0) ? glyph[a / 10] : BLANK;
      3: return (m_neg && a != 0) ? MINUS : BLANK;
      default: return BLANK;
    endcase
  endfunction

  task automatic check_model();
    int pc;
    int idx;
    logic [3:0] ea;
    pc  = t % DIV;
    idx = (t / DIV) % 4;
    ea  = 4'b1111;
    if (m_en && pc >= GAP) ea[idx] = 1'b0;
    chk("an", {3'b0, an}, {3'b0, ea});
    chk("seg", seg, exp_glyph(idx));
  endtask

  // Called at posedge+1; drives inputs, takes one edge, checks outputs
  task automatic cyc(input logic l, input logic [3:0] m,
                     input logic s, input logic e);
    ld  = l;
    mag = m;
    sg  = s;
    en  = e;
    @(posedge clk);
    t++;
    if (l) begin
      m_val = int'(m);
      m_neg = s;
    end
    m_en = e;
    #1;
    check_model();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    t = 0;
    m_val = 0;
    m_neg = 1'b0;
    chk("rst_an", {3'b0, an}, 7'b0001111);
    chk("rst_seg", seg, glyph[0]);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic frame_vec(input vec_t v);
    cyc(1'b1, v.mag, v.sg, 1'b1);
    for (int k = 0; k < 4 * DIV; k++) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
      if (t % DIV == GAP) begin
        case ((t / DIV) % 4)
          0: chk("vec_d0", seg, v.d0);
          1: chk("vec_d1", seg, v.d1);
          2: chk("vec_d2", seg, BLANK);
          default: chk("vec_d3", seg, v.d3);
        endcase
      end
    end
  endtask

  initial begin
    int on_cnt [0:3];
    int off_cnt;
    int bad_hot;
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000};
    vecs[0] = '{4'd11, 1'b0, glyph[1], glyph[1], BLANK};
    vecs[1] = '{4'd7,  1'b1, glyph[7], BLANK,    MINUS};
    vecs[2] = '{4'd0,  1'b1, glyph[0], BLANK,    BLANK};
    vecs[3] = '{4'd15, 1'b1, glyph[5], glyph[1], MINUS};
    vecs[4] = '{4'd10, 1'b0, glyph[0], glyph[1], BLANK};
    vecs[5] = '{4'd9,  1'b0, glyph[9], BLANK,    BLANK};
    vecs[6] = '{4'd12, 1'b1, glyph[2], glyph[1], MINUS};

    // Reset held across edges
    #12;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("hold_an", {3'b0, an}, 7'b0001111);
      chk("hold_seg", seg, glyph[0]);
    end
    rst_n = 1'b1;

    // Scan and gap over one frame
    for (int i = 0; i < 4; i++) on_cnt[i] = 0;
    off_cnt = 0;
    bad_hot = 0;
    for (int k = 0; k < 4 * DIV; k++) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
      if (an == 4'b1111) off_cnt++;
      else if ($countones(~an) != 1) bad_hot++;
      else for (int i = 0; i < 4; i++) if (!an[i]) on_cnt[i]++;
    end
    for (int i = 0; i < 4; i++)
      chk("slot_on", 7'(on_cnt[i]), 7'(DIV - GAP));
    chk("gap_off", 7'(off_cnt), 7'(4 * GAP));
    chk("one_hot", 7'(bad_hot), 7'd0);

    // Table of captured values over full frames
    foreach (vecs[i]) frame_vec(vecs[i]);

    // Enable drop mid-slot, then restore
    while (t % DIV != 4) cyc(1'b0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("en_off", {3'b0, an}, 7'b0001111);
    for (int k = 0; k < 6; k++) cyc(1'b0, 4'd0, 1'b0, 1'b1);

    // Reset in the digit-3 slot clears the captured value
    cyc(1'b1, 4'd13, 1'b1, 1'b1);
    while (!((t / DIV) % 4 == 3 && t % DIV >= 4))
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
    async_reset();
    for (int k = 0; k < 4 * DIV; k++) cyc(1'b0, 4'd0, 1'b0, 1'b1);

    // Last-wins capture on consecutive cycles
    cyc(1'b1, 4'd15, 1'b0, 1'b1);
    cyc(1'b1, 4'd3, 1'b0, 1'b1);
    for (int k = 0; k < 4 * DIV; k++) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
      if (t % DIV == GAP && (t / DIV) % 4 == 0) chk("last_d0", seg, glyph[3]);
      if (t % DIV == GAP && (t / DIV) % 4 == 1) chk("last_d1", seg, BLANK);
    end

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
